// File: rtl/mach_chia_xung_1hz_if.sv
`default_nettype none
// mach_chia_xung_1hz_if: carries the divided square wave out of the divider.
// Revision: 1.0
interface mach_chia_xung_1hz_if;
  logic q;

  modport master (output q);
  modport slave  (input  q);
endinterface
`default_nettype wire

// File: rtl/mach_chia_xung_1hz.sv
`default_nettype none
// mach_chia_xung_1hz: divides clk by CLK_HZ/OUT_HZ into a registered square wave.
// Revision: 1.0
module mach_chia_xung_1hz #(
  parameter int CLK_HZ = 50_000_000,
  parameter int OUT_HZ = 1
) (
  input  wire                          clk,
  input  wire                          rst_n,
  mach_chia_xung_1hz_if.master         q_if
);

  // OUT_HZ is guarded so an illegal value reaches the check below instead of a divide by zero.
  localparam int DIV = (OUT_HZ >= 1) ? (CLK_HZ / OUT_HZ) : 0;
  localparam int LO  = (DIV + 1) / 2;
  localparam int HI  = DIV / 2;
  localparam int CW  = (LO > 1) ? $clog2(LO) : 1;

  localparam logic [CW-1:0] LO_LAST = CW'(LO - 1);
  localparam logic [CW-1:0] HI_LAST = CW'(HI - 1);

  generate
    if (OUT_HZ < 1 || DIV < 2) begin : g_bad_param
      $error("mach_chia_xung_1hz: need OUT_HZ >= 1 and CLK_HZ/OUT_HZ >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q,   q_d;

  // q doubles as the phase flag: low phase lasts LO cycles, high phase HI cycles.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    q_d   = q_q;
    if (!q_q) begin
      if (cnt_q == LO_LAST) begin
        cnt_d = '0;
        q_d   = 1'b1;
      end
    end else begin
      if (cnt_q == HI_LAST) begin
        cnt_d = '0;
        q_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q_if.q = q_q;

endmodule
`default_nettype wire

// File: tb/tb_mach_chia_xung_1hz.sv
`default_nettype none
// tb_mach_chia_xung_1hz: directed checks of four divider configurations.
// Revision: 1.0
module tb_mach_chia_xung_1hz;

  logic clk;
  logic rst_n;

  mach_chia_xung_1hz_if if10 ();
  mach_chia_xung_1hz_if if7 ();
  mach_chia_xung_1hz_if if2 ();
  mach_chia_xung_1hz_if if5 ();

  // DIV=10, DIV=7, DIV=2 and DIV=5 (11/2, remainder dropped)
  mach_chia_xung_1hz #(.CLK_HZ(10), .OUT_HZ(1)) u_div10 (.clk(clk), .rst_n(rst_n), .q_if(if10.master));
  mach_chia_xung_1hz #(.CLK_HZ(7),  .OUT_HZ(1)) u_div7  (.clk(clk), .rst_n(rst_n), .q_if(if7.master));
  mach_chia_xung_1hz #(.CLK_HZ(2),  .OUT_HZ(1)) u_div2  (.clk(clk), .rst_n(rst_n), .q_if(if2.master));
  mach_chia_xung_1hz #(.CLK_HZ(11), .OUT_HZ(2)) u_div5  (.clk(clk), .rst_n(rst_n), .q_if(if5.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   edge_no;
    logic e10;
    logic e7;
    logic e2;
    logic e5;
  } vec_t;

  vec_t vecs[22];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_q10"}, if10.q, 1'b0);
    chk({tag, "_q7"},  if7.q,  1'b0);
    chk({tag, "_q2"},  if2.q,  1'b0);
    chk({tag, "_q5"},  if5.q,  1'b0);
  endtask

  initial begin
    // Expected q after rising edge n (index 0 = still in reset), bit 0 is leftmost.
    logic [0:21] pat10;
    logic [0:21] pat7;
    logic [0:21] pat2;
    logic [0:21] pat5;
    int rise10, rise7, rise2, rise5;
    int found;

    pat10 = 22'b0000011111000001111100;
    pat7  = 22'b0000111000011100001110;
    pat2  = 22'b0101010101010101010101;
    pat5  = 22'b0001100011000110001100;
    for (int i = 0; i < 22; i++)
      vecs[i] = '{edge_no: i, e10: pat10[i], e7: pat7[i], e2: pat2[i], e5: pat5[i]};

    rst_n = 1'b0;
    #2;
    chk_all_low("reset_no_clk");
    repeat (3) @(posedge clk);
    #1;
    chk_all_low("reset_held");

    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n < 22; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("div10_e%0d", vecs[n].edge_no), if10.q, vecs[n].e10);
      chk($sformatf("div7_e%0d",  vecs[n].edge_no), if7.q,  vecs[n].e7);
      chk($sformatf("div2_e%0d",  vecs[n].edge_no), if2.q,  vecs[n].e2);
      chk($sformatf("div5_e%0d",  vecs[n].edge_no), if5.q,  vecs[n].e5);
    end

    // DIV=7 over ten more periods: low for phases 0..3, high for 4..6.
    for (int n = 22; n < 22 + 70; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("div7_long_e%0d", n), if7.q, ((n % 7) >= 4) ? 1'b1 : 1'b0);
    end

    // Reset asserted between edges while the DIV=10 output is high.
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(posedge clk);
      #1;
      if (if10.q === 1'b1) found = 1;
    end
    chk_int("find_high_phase", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_low("async_assert");
    repeat (2) @(posedge clk);
    #1;
    chk_all_low("async_held");

    @(negedge clk);
    rst_n = 1'b1;
    rise10 = 0; rise7 = 0; rise2 = 0; rise5 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (rise10 == 0 && if10.q === 1'b1) rise10 = k;
      if (rise7  == 0 && if7.q  === 1'b1) rise7  = k;
      if (rise2  == 0 && if2.q  === 1'b1) rise2  = k;
      if (rise5  == 0 && if5.q  === 1'b1) rise5  = k;
    end
    chk_int("restart_rise_div10", rise10, 5);
    chk_int("restart_rise_div7",  rise7,  4);
    chk_int("restart_rise_div2",  rise2,  1);
    chk_int("restart_rise_div5",  rise5,  3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
